alu_arbiter: RTL and testbench

Shares one alu_32 instance between two requesters, e.g. the decode/execute path and a multi-cycle address/branch helper. Each requester uses a valid/ready request handshake. A round-robin arbiter grants one request at a time, registers its operands onto the ALU inputs and waits ALU_LAT cycles. It then returns the ALU outputs on a shared, tagged response channel with backpressure. Only one operation is in flight at a time.

---
 rtl/alu_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between two valid/ready requesters and returns a tagged, backpressured response.
// Optional ALU_ARB_OPCHK_EN: illegal opcodes are answered with rsp_err instead of being issued to the ALU.

module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_s,
    input  logic [WIDTH-1:0] req0_t,
    input  logic [3:0]       req0_control,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_s,
    input  logic [WIDTH-1:0] req1_t,
    input  logic [3:0]       req1_control,
    output logic [WIDTH-1:0] alu_s,
    output logic [WIDTH-1:0] alu_t,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             rsp_cout,
    output logic             rsp_err,
    output logic             busy
);

    localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

`ifdef ALU_ARB_OPCHK_EN
    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'hC: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction
`endif

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_s_q, alu_s_d, alu_t_q, alu_t_d;
    logic [3:0]       alu_control_q, alu_control_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d, rsp_overflow_q, rsp_overflow_d;
    logic             rsp_cout_q, rsp_cout_d, rsp_err_q, rsp_err_d;
    logic             busy_q, busy_d;

    logic             grant0_s, grant1_s, grant_s;
    logic [WIDTH-1:0] sel_s_s, sel_t_s;
    logic [3:0]       sel_control_s;

    // A lone requester always wins; on contention the pointer side wins.
    assign grant0_s = (state_q == IDLE) & req0_valid & (~ptr_q | ~req1_valid);
    assign grant1_s = (state_q == IDLE) & req1_valid & (ptr_q | ~req0_valid);
    assign grant_s  = grant0_s | grant1_s;

    assign sel_s_s       = grant1_s ? req1_s       : req0_s;
    assign sel_t_s       = grant1_s ? req1_t       : req0_t;
    assign sel_control_s = grant1_s ? req1_control : req0_control;

    assign req0_ready   = grant0_s;
    assign req1_ready   = grant1_s;
    assign alu_s        = alu_s_q;
    assign alu_t        = alu_t_q;
    assign alu_control  = alu_control_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_cout     = rsp_cout_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = busy_q;

    // Next-state and next-output computation for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        alu_s_d        = alu_s_q;
        alu_t_d        = alu_t_q;
        alu_control_d  = alu_control_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_cout_d     = rsp_cout_q;
        rsp_err_d      = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    ptr_d    = ~grant1_s;
                    rsp_id_d = grant1_s;
`ifdef ALU_ARB_OPCHK_EN
                    if (!op_legal(sel_control_s)) begin
                        // Rejected opcodes never touch the ALU registers.
                        state_d        = RESP;
                        rsp_valid_d    = 1'b1;
                        rsp_err_d      = 1'b1;
                        rsp_result_d   = '0;
                        rsp_zero_d     = 1'b0;
                        rsp_overflow_d = 1'b0;
                        rsp_cout_d     = 1'b0;
                    end else begin
                        state_d       = EXEC;
                        cnt_d         = CNT_LOAD;
                        alu_s_d       = sel_s_s;
                        alu_t_d       = sel_t_s;
                        alu_control_d = sel_control_s;
                    end
`else
                    state_d       = EXEC;
                    cnt_d         = CNT_LOAD;
                    alu_s_d       = sel_s_s;
                    alu_t_d       = sel_t_s;
                    alu_control_d = sel_control_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d        = RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_result_d   = alu_result;
                    rsp_zero_d     = alu_zero;
                    rsp_overflow_d = alu_overflow;
                    rsp_cout_d     = alu_cout;
                    rsp_err_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            ptr_q          <= 1'b0;
            cnt_q          <= '0;
            alu_s_q        <= '0;
            alu_t_q        <= '0;
            alu_control_q  <= 4'h0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_cout_q     <= 1'b0;
            rsp_err_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            alu_s_q        <= alu_s_d;
            alu_t_q        <= alu_t_d;
            alu_control_q  <= alu_control_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_cout_q     <= rsp_cout_d;
            rsp_err_q      <= rsp_err_d;
            busy_q         <= busy_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a one-cycle registered ALU model (ALU_LAT=1).
// Covers both builds of ALU_ARB_OPCHK_EN.

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_s, req0_t, req1_s, req1_t;
    logic [3:0]  req0_control, req1_control;
    logic [31:0] alu_s, alu_t, alu_result;
    logic [3:0]  alu_control;
    logic        alu_zero, alu_overflow, alu_cout;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_overflow, rsp_cout, rsp_err, busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(32), .ALU_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_s(req0_s),
        .req0_t(req0_t), .req0_control(req0_control),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_s(req1_s),
        .req1_t(req1_t), .req1_control(req1_control),
        .alu_s(alu_s), .alu_t(alu_t), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_overflow(rsp_overflow), .rsp_cout(rsp_cout),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference ALU: {cout, overflow, zero, result}
    function automatic logic [34:0] alu_eval(input logic [31:0] s, input logic [31:0] t,
                                             input logic [3:0] c);
        logic [32:0] sum;
        logic [31:0] r;
        logic        co, ov;
        r = 32'd0; co = 1'b0; ov = 1'b0; sum = 33'd0;
        case (c)
            4'h0: r = s & t;
            4'h1: r = s | t;
            4'h2: begin
                sum = {1'b0, s} + {1'b0, t};
                r = sum[31:0]; co = sum[32];
                ov = (s[31] == t[31]) && (r[31] != s[31]);
            end
            4'h3: begin
                sum = {1'b0, s} + {1'b0, ~t} + 33'd1;
                r = sum[31:0]; co = sum[32];
                ov = (s[31] != t[31]) && (r[31] != s[31]);
            end
            4'h7: r = ($signed(s) < $signed(t)) ? 32'd1 : 32'd0;
            4'hC: r = ~(s | t);
            default: r = 32'd0;
        endcase
        return {co, ov, (r == 32'd0), r};
    endfunction

    always_ff @(posedge clk) begin
        {alu_cout, alu_overflow, alu_zero, alu_result} <= alu_eval(alu_s, alu_t, alu_control);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wait_rsp(input int max_cycles);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
        checks++; if ({alu_s, alu_t, alu_control} !== 68'd0) begin errors++; $display("FAIL reset_alu: got %h %h %h expected 0", alu_s, alu_t, alu_control); end
        checks++; if ({rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_cout, rsp_err} !== 37'd0) begin errors++; $display("FAIL reset_rsp_fields: got id=%b res=%h err=%b expected 0", rsp_id, rsp_result, rsp_err); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        req0_s = 32'd3; req0_t = 32'd1; req0_control = 4'h2; req0_valid = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_n1: got %b expected 1", busy); end
        checks++; if ({alu_s, alu_t, alu_control} !== {32'd3, 32'd1, 4'h2}) begin errors++; $display("FAIL single_alu_regs: got %h %h %h expected 3 1 2", alu_s, alu_t, alu_control); end
        tick();
        checks++; if ({busy, rsp_valid} !== 2'b10) begin errors++; $display("FAIL single_n2: got busy,valid=%b expected 10", {busy, rsp_valid}); end
        tick();
        checks++; if ({busy, rsp_valid} !== 2'b11) begin errors++; $display("FAIL single_n3: got busy,valid=%b expected 11", {busy, rsp_valid}); end
        checks++; if ({rsp_id, rsp_result, rsp_zero} !== {1'b0, 32'd4, 1'b0}) begin errors++; $display("FAIL single_rsp: got id=%b res=%h zero=%b expected 0 4 0", rsp_id, rsp_result, rsp_zero); end
        tick();
        checks++; if ({busy, rsp_valid} !== 2'b00) begin errors++; $display("FAIL single_n4: got busy,valid=%b expected 00", {busy, rsp_valid}); end
    endtask

    task automatic test_contention();
        logic        exp_id;
        logic [31:0] exp_res;
        do_reset();
        rsp_ready = 1'b1;
        req0_s = 32'h0F; req0_t = 32'hFF; req0_control = 4'h0;
        req1_s = 32'h10; req1_t = 32'h01; req1_control = 4'h1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_id  = (g % 2 == 1);
            exp_res = exp_id ? 32'h11 : 32'h0F;
            wait_rsp(10);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL contention_timeout: grant %0d got no response", g); end
            checks++; if ({rsp_id, rsp_result} !== {exp_id, exp_res}) begin errors++; $display("FAIL contention_rsp%0d: got id=%b res=%h expected id=%b res=%h", g, rsp_id, rsp_result, exp_id, exp_res); end
            if (g == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req0_s = 32'hFFFF_FFFF; req0_t = 32'h1; req0_control = 4'h2; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        req1_s = 32'h1; req1_t = 32'h1; req1_control = 4'h2; req1_valid = 1'b1;
        wait_rsp(10);
        for (int i = 0; i < 5; i++) begin
            checks++; if ({rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_overflow} !== {1'b1, 32'd0, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL bp_hold%0d: got v=%b res=%h z=%b c=%b o=%b expected 1 0 1 1 0", i, rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_overflow); end
            checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready%0d: got %b expected 00", i, {req0_ready, req1_ready}); end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        tick();
        checks++; if ({busy, rsp_valid, req1_ready} !== 3'b001) begin errors++; $display("FAIL bp_idle: got busy,valid,req1_ready=%b expected 001", {busy, rsp_valid, req1_ready}); end
        req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        req1_s = 32'd1; req1_t = 32'd2; req1_control = 4'h7; req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({busy, rsp_valid} !== 2'b00) begin errors++; $display("FAIL midrst_state: got busy,valid=%b expected 00", {busy, rsp_valid}); end
        checks++; if ({alu_s, alu_t, alu_control} !== 68'd0) begin errors++; $display("FAIL midrst_alu: got %h %h %h expected 0", alu_s, alu_t, alu_control); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp%0d: got %b expected 0", i, rsp_valid); end
        end
        req0_s = 32'd5; req0_t = 32'd2; req0_control = 4'h1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL midrst_grant: got %b expected 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(10);
        checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'd7}) begin errors++; $display("FAIL midrst_rsp: got v=%b id=%b res=%h expected 1 0 7", rsp_valid, rsp_id, rsp_result); end
        tick();
    endtask

    task automatic test_lone();
        int grant_cyc[3];
        int n_grant, n_rsp, cyc;
        do_reset();
        rsp_ready = 1'b1;
        req1_s = 32'd5; req1_t = 32'd6; req1_control = 4'h2; req1_valid = 1'b1;
        n_grant = 0; n_rsp = 0; cyc = 0;
        #1;
        while (cyc < 40 && n_rsp < 3) begin
            if (n_grant == 3) req1_valid = 1'b0;
            #1;
            if (req1_ready === 1'b1 && n_grant < 3) begin
                grant_cyc[n_grant] = cyc;
                n_grant++;
            end
            if (rsp_valid === 1'b1) begin
                n_rsp++;
                checks++; if ({rsp_id, rsp_result} !== {1'b1, 32'd11}) begin errors++; $display("FAIL lone_rsp%0d: got id=%b res=%h expected 1 0000000b", n_rsp, rsp_id, rsp_result); end
            end
            tick();
            cyc++;
        end
        checks++; if (n_rsp !== 3) begin errors++; $display("FAIL lone_count: got %0d responses expected 3", n_rsp); end
        if (n_grant == 3) begin
            checks++; if (grant_cyc[1] - grant_cyc[0] !== 4) begin errors++; $display("FAIL lone_gap1: got %0d expected 4", grant_cyc[1] - grant_cyc[0]); end
            checks++; if (grant_cyc[2] - grant_cyc[1] !== 4) begin errors++; $display("FAIL lone_gap2: got %0d expected 4", grant_cyc[2] - grant_cyc[1]); end
        end else begin
            checks++; errors++; $display("FAIL lone_grants: got %0d grants expected 3", n_grant);
        end
    endtask

    task automatic test_opchk();
        do_reset();
        rsp_ready = 1'b1;
        req0_s = 32'd7; req0_t = 32'd8; req0_control = 4'h5; req0_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL opchk_ready: got %b expected 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
`ifdef ALU_ARB_OPCHK_EN
        checks++; if ({rsp_valid, rsp_err, rsp_id, rsp_result} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin errors++; $display("FAIL opchk_rsp: got v=%b err=%b id=%b res=%h expected 1 1 0 0", rsp_valid, rsp_err, rsp_id, rsp_result); end
        checks++; if ({rsp_zero, rsp_overflow, rsp_cout} !== 3'b000) begin errors++; $display("FAIL opchk_flags: got %b expected 000", {rsp_zero, rsp_overflow, rsp_cout}); end
        checks++; if ({alu_s, alu_t, alu_control} !== 68'd0) begin errors++; $display("FAIL opchk_alu: got %h %h %h expected 0", alu_s, alu_t, alu_control); end
`else
        checks++; if ({alu_s, alu_t, alu_control} !== {32'd7, 32'd8, 4'h5}) begin errors++; $display("FAIL opchk_alu: got %h %h %h expected 7 8 5", alu_s, alu_t, alu_control); end
        wait_rsp(10);
        checks++; if ({rsp_valid, rsp_err, rsp_id} !== 3'b100) begin errors++; $display("FAIL opchk_rsp: got v=%b err=%b id=%b expected 1 0 0", rsp_valid, rsp_err, rsp_id); end
`endif
        tick();
        // Pointer must have advanced past requester 0 in both builds
        req0_control = 4'h2; req1_s = 32'd2; req1_t = 32'd2; req1_control = 4'h3;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL opchk_ptr: got %b expected 01", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(10);
        checks++; if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, 1'b1, 32'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL opchk_next: got v=%b id=%b res=%h z=%b err=%b expected 1 1 0 1 0", rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err); end
        tick();
    endtask

    initial begin
        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_s = 32'd0; req0_t = 32'd0; req0_control = 4'h0;
        req1_valid = 1'b0; req1_s = 32'd0; req1_t = 32'd0; req1_control = 4'h0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_lone();
        test_opchk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
